apple1_text_capture: RTL

- Reverse direction of the existing ASCII text-input download path.
- Captures the characters the 6502 writes to the Apple-I display port ($D012) into an on-chip byte buffer.
- Lets the HPS read that buffer back as a TXT file through the ioctl upload handshake.
- Sits beside the apple1 core in the top level, on clk25, fed by the core's display-write strobe and data.

---
 rtl/apple1_text_capture.sv | 132 +++++++++++++
 1 files changed

// File: rtl/apple1_text_capture.sv
// Apple-I display capture: records characters written to $D012 into a
// byte buffer and serves them to the HPS over the ioctl upload handshake.
module apple1_text_capture #(
    parameter int ADDR_W          = 13,
    parameter bit CR_TO_LF        = 1'b1,
    parameter bit CLEAR_ON_UPLOAD = 1'b1
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              disp_wr,
    input  logic [6:0]        disp_data,
    input  logic              capture_en,
    input  logic              clear,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic [ADDR_W:0]   capture_len,
    output logic              overflow,
    output logic              busy
);

    localparam logic [1:0] S_CAPTURE = 2'd0;
    localparam logic [1:0] S_UPLOAD  = 2'd1;
    localparam logic [1:0] S_CLR     = 2'd2;

    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              char_ok;
    logic [7:0]        char_byte;
    logic              full;
    logic              clr_req;
    logic              take;
    logic              wr_en;
    logic              ovf_set;
    logic              in_range;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_q;
    logic              hit;
    logic [7:0]        mem [2**ADDR_W];

    // Printable ASCII plus CR survive; other control codes and DEL are dropped.
    always_comb begin
        char_ok   = 1'b0;
        char_byte = {1'b0, disp_data};
        if (disp_data == 7'h0D) begin
            char_ok   = 1'b1;
            char_byte = CR_TO_LF ? 8'h0A : 8'h0D;
        end else if (disp_data >= 7'h20 && disp_data <= 7'h7E) begin
            char_ok = 1'b1;
        end
    end

    assign full     = capture_len[ADDR_W];
    // An upload starting in the same cycle takes priority over clear.
    assign clr_req  = clear & ~ioctl_upload;
    assign take     = (state == S_CAPTURE) & capture_en & disp_wr
                    & char_ok & ~clr_req;
    assign wr_en    = take & ~full;
    assign ovf_set  = take & full;
    assign in_range = {1'b0, ioctl_addr} < capture_len;
    assign busy     = (state != S_CAPTURE);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_CAPTURE: begin
                if (ioctl_upload) begin
                    state_nx = S_UPLOAD;
                end else if (clear) begin
                    state_nx = S_CLR;
                end
            end
            S_UPLOAD: begin
                if (!ioctl_upload) begin
                    state_nx = CLEAR_ON_UPLOAD ? S_CLR : S_CAPTURE;
                end
            end
            S_CLR: begin
                state_nx = S_CAPTURE;
            end
            default: begin
                state_nx = S_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_CAPTURE;
            capture_len <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_CLR) begin
                capture_len <= '0;
                overflow    <= 1'b0;
            end else begin
                if (wr_en) begin
                    capture_len <= capture_len + LEN_ONE;
                end
                if (ovf_set) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Single-port RAM: a capture write owns the port for its cycle.
    assign ram_addr = wr_en ? capture_len[ADDR_W-1:0] : ioctl_addr;

    always_ff @(posedge clk25) begin
        if (wr_en) begin
            mem[ram_addr] <= char_byte;
        end else if (ioctl_rd) begin
            ram_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            hit <= 1'b0;
        end else if (ioctl_rd) begin
            hit <= in_range & ~wr_en;
        end
    end

    assign ioctl_din = hit ? ram_q : 8'h00;

endmodule
